// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM block: command encodings, default timing and the bound clamp.
// Latency: n/a (package). Backpressure: none.
package servo_pkg;

  localparam logic [1:0] SWT_HOLD = 2'b00;
  localparam logic [1:0] SWT_INC  = 2'b01;
  localparam logic [1:0] SWT_DEC  = 2'b10;

  localparam int TICK_DIV_DEFAULT    = 125;
  localparam int FRAME_TICKS_DEFAULT = 20000;
  localparam int POS_MIN_DEFAULT     = 500;
  localparam int POS_MAX_DEFAULT     = 2500;

  // Upper bound applied first, lower bound last, so an inverted window (lo > hi) yields lo.
  function automatic logic [31:0] clamp(input logic [31:0] x, input logic [31:0] lo,
                                        input logic [31:0] hi);
    logic [31:0] t;
    t = (x > hi) ? hi : x;
    return (t < lo) ? lo : t;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: position ramp/clamp register, per-frame shadow, and PWM compare.
// Latency: pos updates on frame_end; pwm is registered 1 clk after fcnt. Backpressure: none.
module servo_channel
  import servo_pkg::*;
#(
  parameter int POS_W   = 15,
  parameter int SPEED_W = 4,
  parameter int FCNT_W  = 15,
  parameter int OFFSET  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_end,
  input  logic [FCNT_W-1:0]  fcnt,
  input  logic [1:0]         swt,
  input  logic [SPEED_W-1:0] speed,
  input  logic [POS_W-1:0]   pos_ini,
  input  logic [POS_W-1:0]   pos_max,
  input  logic [POS_W-1:0]   pos_min,
  input  logic               load,
  output logic [POS_W-1:0]   pos,
  output logic               pwm
);

  logic [POS_W-1:0]        shadow;
  logic [POS_W-1:0]        ini_c;
  logic [POS_W-1:0]        pos_nxt;
  logic [POS_W:0]          sum;
  logic signed [POS_W+1:0] diff;
  logic [31:0]             rel;
  logic                    pwm_nxt;

  assign ini_c = POS_W'(clamp(32'(pos_ini), 32'(pos_min), 32'(pos_max)));

  always_comb begin
    sum     = {1'b0, pos} + (POS_W+1)'(speed);
    diff    = $signed({2'b00, pos}) - $signed((POS_W+2)'(speed));
    pos_nxt = POS_W'(clamp(32'(pos), 32'(pos_min), 32'(pos_max)));
    case (swt)
      SWT_INC: pos_nxt = (sum > {1'b0, pos_max}) ? pos_max : sum[POS_W-1:0];
      SWT_DEC: pos_nxt = (diff < $signed({2'b00, pos_min})) ? pos_min : diff[POS_W-1:0];
      default: ;
    endcase
  end

  // Unsigned wrap makes fcnt < OFFSET a huge value, so one compare covers both pulse edges.
  assign rel     = 32'(fcnt) - 32'(OFFSET);
  assign pwm_nxt = rel < 32'(shadow);

  always_ff @(posedge clk) begin
    if (rst) begin
      pos    <= ini_c;
      shadow <= ini_c;
      pwm    <= 1'b0;
    end else begin
      if (load)
        pos <= ini_c;
      else if (frame_end)
        pos <= pos_nxt;
      if (frame_end)
        shadow <= pos;
      pwm <= pwm_nxt;
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: shared tick prescaler and frame counter feeding NUM_CH channels.
// Latency: frame_start 1 clk after frame end, pwm 1 clk after fcnt. Backpressure: none.
// SERVO_STAGGER_EN: when defined, channel k's pulse starts k*STAGGER_TICKS into the frame.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int POS_W         = 15,
  parameter int SPEED_W       = 4,
  parameter int TICK_DIV      = TICK_DIV_DEFAULT,
  parameter int FRAME_TICKS   = FRAME_TICKS_DEFAULT,
  parameter int STAGGER_TICKS = 2500
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*NUM_CH-1:0]       swt,
  input  logic [SPEED_W*NUM_CH-1:0] speed,
  input  logic [POS_W*NUM_CH-1:0]   pos_ini,
  input  logic [POS_W*NUM_CH-1:0]   pos_max,
  input  logic [POS_W*NUM_CH-1:0]   pos_min,
  input  logic [NUM_CH-1:0]         load,
  output logic [POS_W*NUM_CH-1:0]   pos,
  output logic [NUM_CH-1:0]         pwm,
  output logic                      frame_start
);

  localparam int PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FCNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
`ifdef SERVO_STAGGER_EN
  localparam bit STAGGER_EN = 1'b1;
`else
  localparam bit STAGGER_EN = 1'b0;
`endif
  localparam int STAGGER_STEP = STAGGER_EN ? STAGGER_TICKS : 0;

  logic [PS_W-1:0]   ps;
  logic [FCNT_W-1:0] fcnt;
  logic              tick;
  logic              frame_end;

  assign tick      = (ps == PS_W'(TICK_DIV - 1));
  assign frame_end = tick && (fcnt == FCNT_W'(FRAME_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      ps          <= '0;
      fcnt        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end;
      ps          <= tick ? '0 : ps + 1'b1;
      if (frame_end)
        fcnt <= '0;
      else if (tick)
        fcnt <= fcnt + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    servo_channel #(
      .POS_W  (POS_W),
      .SPEED_W(SPEED_W),
      .FCNT_W (FCNT_W),
      .OFFSET (k * STAGGER_STEP)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .frame_end(frame_end),
      .fcnt     (fcnt),
      .swt      (swt[2*k +: 2]),
      .speed    (speed[SPEED_W*k +: SPEED_W]),
      .pos_ini  (pos_ini[POS_W*k +: POS_W]),
      .pos_max  (pos_max[POS_W*k +: POS_W]),
      .pos_min  (pos_min[POS_W*k +: POS_W]),
      .load     (load[k]),
      .pos      (pos[POS_W*k +: POS_W]),
      .pwm      (pwm[k])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi with a shortened frame (2 clk/tick, 40 ticks/frame).
// Expected positions, widths and rise points are hand-computed per frame.
module tb_servo_pwm_multi;

  localparam int NUM_CH        = 4;
  localparam int POS_W         = 15;
  localparam int SPEED_W       = 4;
  localparam int TICK_DIV      = 2;
  localparam int FRAME_TICKS   = 40;
  localparam int STAGGER_TICKS = 8;
  localparam int FRAME_CLK     = TICK_DIV * FRAME_TICKS;
`ifdef SERVO_STAGGER_EN
  localparam int STEP = STAGGER_TICKS;
`else
  localparam int STEP = 0;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic [2*NUM_CH-1:0]       swt;
  logic [SPEED_W*NUM_CH-1:0] speed;
  logic [POS_W*NUM_CH-1:0]   pos_ini;
  logic [POS_W*NUM_CH-1:0]   pos_max;
  logic [POS_W*NUM_CH-1:0]   pos_min;
  logic [NUM_CH-1:0]         load;
  logic [POS_W*NUM_CH-1:0]   pos;
  logic [NUM_CH-1:0]         pwm;
  logic                      frame_start;

  int checks = 0;
  int errors = 0;
  int hi_cnt[NUM_CH];
  int rise_at[NUM_CH];

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .NUM_CH(NUM_CH), .POS_W(POS_W), .SPEED_W(SPEED_W), .TICK_DIV(TICK_DIV),
    .FRAME_TICKS(FRAME_TICKS), .STAGGER_TICKS(STAGGER_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .swt(swt), .speed(speed), .pos_ini(pos_ini),
    .pos_max(pos_max), .pos_min(pos_min), .load(load), .pos(pos), .pwm(pwm),
    .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [1:0] s, input int spd, input int ini,
                        input int lo, input int hi);
    swt[2*k +: 2]               = s;
    speed[SPEED_W*k +: SPEED_W] = SPEED_W'(spd);
    pos_ini[POS_W*k +: POS_W]   = POS_W'(ini);
    pos_min[POS_W*k +: POS_W]   = POS_W'(lo);
    pos_max[POS_W*k +: POS_W]   = POS_W'(hi);
  endtask

  task automatic check_pos(input int ph, input int e0, input int e1, input int e2, input int e3);
    int e[NUM_CH];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < NUM_CH; k++)
      chk($sformatf("pos_f%0d_ch%0d", ph, k), 32'(pos[POS_W*k +: POS_W]), e[k]);
  endtask

  task automatic stim(input int ph, input int i);
    case (ph)
      2: begin
        if (i == 1) begin
          pos_max[0 +: POS_W]     = POS_W'(10);
          pos_ini[POS_W +: POS_W] = POS_W'(10);
        end
        if (i == FRAME_CLK - 1) load = 4'b0010;
      end
      3: if (i == 0) load = '0;
      4: if (i == 1) begin
        swt[4 +: 2]                 = 2'b01;
        speed[2*SPEED_W +: SPEED_W] = '0;
        pos_min[3*POS_W +: POS_W]   = POS_W'(30);
        pos_max[3*POS_W +: POS_W]   = POS_W'(20);
      end
      default: ;
    endcase
  endtask

  // Entered on the negedge where frame_start is high; leaves on the next such negedge.
  task automatic measure(input int ph);
    for (int k = 0; k < NUM_CH; k++) begin
      hi_cnt[k]  = 0;
      rise_at[k] = -1;
    end
    for (int i = 0; i < FRAME_CLK; i++) begin
      stim(ph, i);
      for (int k = 0; k < NUM_CH; k++)
        if (pwm[k] === 1'b1) begin
          hi_cnt[k]++;
          if (rise_at[k] < 0) rise_at[k] = i;
        end
      @(negedge clk);
    end
    chk($sformatf("period_f%0d", ph), 32'(frame_start), 1);
  endtask

  task automatic check_frame(input int ph, input int w0, input int w1, input int w2, input int w3);
    int w[NUM_CH];
    w = '{w0, w1, w2, w3};
    for (int k = 0; k < NUM_CH; k++) begin
      chk($sformatf("width_f%0d_ch%0d", ph, k), hi_cnt[k], TICK_DIV * w[k]);
      chk($sformatf("rise_f%0d_ch%0d", ph, k), rise_at[k], 1 + TICK_DIV * STEP * k);
    end
  endtask

  initial begin
    int found;
    int gap;
    int hc;
    rst  = 1'b1;
    load = '0;
    set_ch(0, 2'b00, 3, 15, 5, 25);
    set_ch(1, 2'b01, 3, 24, 5, 25);
    set_ch(2, 2'b10, 3,  7, 5, 25);
    set_ch(3, 2'b00, 3,  2, 5, 25);
    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(pwm), 0);
    chk("rst_fs", 32'(frame_start), 0);
    check_pos(0, 15, 24, 7, 5);
    rst = 1'b0;

    found = 0;
    gap   = 0;
    for (int i = 1; i <= 3 * FRAME_CLK && found == 0; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        found = 1;
        gap   = i;
      end
    end
    chk("first_fs_seen", found, 1);
    chk("first_fs_gap", gap, FRAME_CLK);

    check_pos(1, 15, 25, 5, 5);
    measure(1);
    check_frame(1, 15, 24, 7, 5);
    check_pos(2, 15, 25, 5, 5);
    measure(2);
    check_frame(2, 15, 25, 5, 5);
    check_pos(3, 10, 10, 5, 5);
    measure(3);
    check_frame(3, 15, 25, 5, 5);
    check_pos(4, 10, 13, 5, 5);
    measure(4);
    check_frame(4, 10, 10, 5, 5);
    check_pos(5, 10, 16, 5, 30);
    measure(5);
    check_frame(5, 10, 13, 5, 5);

    // Reset in the middle of a frame, then time the first frame after release.
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pwm", 32'(pwm), 0);
    chk("midrst_fs", 32'(frame_start), 0);
    check_pos(6, 10, 10, 7, 30);
    @(negedge clk);
    rst   = 1'b0;
    found = 0;
    gap   = 0;
    hc    = 0;
    for (int i = 1; i <= 3 * FRAME_CLK && found == 0; i++) begin
      @(negedge clk);
      if (pwm[0] === 1'b1) hc++;
      if (frame_start === 1'b1) begin
        found = 1;
        gap   = i;
      end
    end
    chk("midrst_fs_seen", found, 1);
    chk("midrst_fs_gap", gap, FRAME_CLK);
    chk("midrst_width_ch0", hc, TICK_DIV * 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
